// File: rtl/axil_master_param.sv
// Single-outstanding AXI4-Lite master: one write or read per start pulse,
// with an optional handshake-stall timeout that aborts back to DONE.
//
// Handshake rule on every channel: a transfer happens on the rising edge where
// VALID and READY are both high; VALID never drops before that edge except on
// timeout abort, and its payload stays stable while VALID is high.
module axil_master_param #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256,
    parameter int RESP_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    // command side
    input  logic                start,
    input  logic                write_en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic [RESP_W-1:0]   resp,
    output logic                done,
    output logic                busy,
    output logic                timeout_err,
    output logic [2:0]          state_dbg,
    // AXI4-Lite write address channel
    output logic [ADDR_W-1:0]   axil_awaddr,
    output logic                axil_awvalid,
    input  logic                axil_awready,
    // write data channel
    output logic [DATA_W-1:0]   axil_wdata,
    output logic [DATA_W/8-1:0] axil_wstrb,
    output logic                axil_wvalid,
    input  logic                axil_wready,
    // write response channel
    input  logic [RESP_W-1:0]   axil_bresp,
    input  logic                axil_bvalid,
    output logic                axil_bready,
    // read address channel
    output logic [ADDR_W-1:0]   axil_araddr,
    output logic                axil_arvalid,
    input  logic                axil_arready,
    // read data channel
    input  logic [DATA_W-1:0]   axil_rdata,
    input  logic [RESP_W-1:0]   axil_rresp,
    input  logic                axil_rvalid,
    output logic                axil_rready
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [RESP_W-1:0] RESP_TMO = RESP_W'(2);
    localparam logic [31:0]       TMO_LIM  = 32'(TIMEOUT);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [RESP_W-1:0]   resp_q;
    logic [15:0]         cnt_q;
    logic                aw_done_q, w_done_q, aw_done_d, w_done_d;
    logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                timeout_err_q;
    logic                aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
    logic                tmo_hit, abort;

    assign aw_hs  = awvalid_q & axil_awready;
    assign w_hs   = wvalid_q  & axil_wready;
    assign b_hs   = bready_q  & axil_bvalid;
    assign ar_hs  = arvalid_q & axil_arready;
    assign r_hs   = rready_q  & axil_rvalid;
    assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

    // Abort on the edge where the stall counter would reach TIMEOUT.
    assign tmo_hit = (TIMEOUT != 0) && !any_hs &&
                     (({16'd0, cnt_q} + 32'd1) >= TMO_LIM);

    always_comb begin
        state_d   = state_q;
        abort     = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = write_en ? ST_WR_REQ : ST_RD_REQ;
            end
            ST_WR_REQ: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WR_RESP;
                end else if (tmo_hit) begin
                    abort   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    state_d = ST_DONE;
                end else if (tmo_hit) begin
                    abort   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RD_REQ: begin
                if (ar_hs) begin
                    state_d = ST_RD_DATA;
                end else if (tmo_hit) begin
                    abort   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RD_DATA: begin
                if (r_hs) begin
                    state_d = ST_DONE;
                end else if (tmo_hit) begin
                    abort   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Channel strobes are registered from the next state so they are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= 16'd0;
        end else begin
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            awvalid_q     <= (state_d == ST_WR_REQ) && !aw_done_d;
            wvalid_q      <= (state_d == ST_WR_REQ) && !w_done_d;
            bready_q      <= (state_d == ST_WR_RESP);
            arvalid_q     <= (state_d == ST_RD_REQ);
            rready_q      <= (state_d == ST_RD_DATA);
            timeout_err_q <= abort;
            if (state_d == ST_IDLE || state_d != state_q || any_hs)
                cnt_q <= 16'd0;
            else if (cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q  <= '0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (b_hs) resp_q <= axil_bresp;
            if (r_hs) begin
                rdata_q <= axil_rdata;
                resp_q  <= axil_rresp;
            end
            if (abort) resp_q <= RESP_TMO;
        end
    end

    assign rdata        = rdata_q;
    assign resp         = resp_q;
    assign done         = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);
    assign timeout_err  = timeout_err_q;
    assign state_dbg    = state_q;
    assign axil_awaddr  = addr_q;
    assign axil_awvalid = awvalid_q;
    assign axil_wdata   = wdata_q;
    assign axil_wstrb   = wstrb_q;
    assign axil_wvalid  = wvalid_q;
    assign axil_bready  = bready_q;
    assign axil_araddr  = addr_q;
    assign axil_arvalid = arvalid_q;
    assign axil_rready  = rready_q;

endmodule
